// File: rtl/dram_mux_model.sv
// Multiplexed-address DRAM model: row/column latched on synchronously detected
// /RAS and /CAS falls, fast page mode, early/late write, CBR and hidden refresh.
// Optional protocol checker enabled by defining DRAM_MUX_PROT_CHECK_EN.
module dram_mux_model #(
   parameter int DW        = 4,
   parameter int RW        = 8,
   parameter int CW        = 6,
   parameter int AW        = 8,
   parameter int COL_LSB   = 1,
   parameter     INIT_FILE = ""
) (
   input  logic          i_MCLK,
   input  logic          i_RST_n,
   input  logic [AW-1:0] i_ADDR,
   input  logic [DW-1:0] i_DIN,
   output logic [DW-1:0] o_DOUT,
   output logic          o_DOUT_VALID,
   input  logic          i_RAS_n,
   input  logic          i_CAS_n,
   input  logic          i_WR_n,
   input  logic          i_RD_n,
   output logic [RW-1:0] o_REFRESH_ROW,
   output logic          o_PROT_ERR
);

   localparam int DEPTH = 1 << (RW + CW);

   typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_CBR} state_t;

   state_t              state_q, state_d;
   logic                ras_q, cas_q;
   logic [RW-1:0]       row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       ref_q, ref_d;
   logic [DW-1:0]       dout_q, dout_d;
   logic                valid_q, valid_d;
   logic [DW-1:0]       mem [DEPTH];

   logic                ras_fall, cas_fall;
   logic                access, wr_en, rd_en;
   logic [RW+CW-1:0]    index;

   assign ras_fall = ras_q & ~i_RAS_n;
   assign cas_fall = cas_q & ~i_CAS_n;
   assign index    = {col_q, row_q};

   // RAS must have been low on both samples, so the hidden-refresh RAS re-fall never touches the array
   assign access = (state_q == S_COL) & ~ras_q & ~i_RAS_n;
   assign wr_en  = access & ~i_WR_n;
   assign rd_en  = access & i_WR_n & ~i_RD_n;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      ref_d   = ref_q;
      if (i_RAS_n && i_CAS_n) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ras_fall) begin
                  if (i_CAS_n) begin
                     state_d = S_ROW;
                     row_d   = i_ADDR[RW-1:0];
                  end else begin
                     state_d = S_CBR;
                     ref_d   = ref_q + 1'b1;
                  end
               end
            end
            S_ROW: begin
               if (i_RAS_n) begin
                  state_d = S_IDLE;
               end else if (cas_fall) begin
                  state_d = S_COL;
                  col_d   = i_ADDR[COL_LSB+CW-1:COL_LSB];
               end
            end
            S_COL: begin
               // RAS high with CAS held low parks here until RAS falls again (hidden refresh)
               if (ras_fall && !i_CAS_n) begin
                  state_d = S_CBR;
                  ref_d   = ref_q + 1'b1;
               end else if (!i_RAS_n && i_CAS_n) begin
                  state_d = S_ROW;
               end
            end
            S_CBR:   state_d = S_CBR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      dout_d  = dout_q;
      valid_d = rd_en;
      if (rd_en) begin
         dout_d = mem[index];
      end
   end

   always_ff @(posedge i_MCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q <= S_IDLE;
         ras_q   <= 1'b1;
         cas_q   <= 1'b1;
         row_q   <= '0;
         col_q   <= '0;
         ref_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ras_q   <= i_RAS_n;
         cas_q   <= i_CAS_n;
         row_q   <= row_d;
         col_q   <= col_d;
         ref_q   <= ref_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   // The array is never reset; its contents survive i_RST_n
   always_ff @(posedge i_MCLK) begin
      if (wr_en) begin
         mem[index] <= i_DIN;
      end
   end

   assign o_DOUT        = dout_q;
   assign o_DOUT_VALID  = valid_q;
   assign o_REFRESH_ROW = ref_q;

`ifdef DRAM_MUX_PROT_CHECK_EN
   logic prot_q, prot_d;
   logic col_seen_q, col_seen_d;
   logic viol;

   always_comb begin
      col_seen_d = col_seen_q;
      if (ras_fall) begin
         col_seen_d = 1'b0;
      end else if (state_q == S_COL) begin
         col_seen_d = 1'b1;
      end
      // An early write is legal on the CAS-fall edge itself, so entering COL counts as inside it
      viol = ((~i_WR_n | ~i_RD_n) && (state_q != S_COL) && (state_d != S_COL))
           | (cas_fall && i_RAS_n && (state_d != S_CBR))
           | ((state_q == S_ROW) && ~ras_q && i_RAS_n && ~col_seen_q && ~i_WR_n);
      prot_d = prot_q | viol;
   end

   always_ff @(posedge i_MCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         prot_q     <= 1'b0;
         col_seen_q <= 1'b0;
      end else begin
         prot_q     <= prot_d;
         col_seen_q <= col_seen_d;
      end
   end

   assign o_PROT_ERR = prot_q;
`else
   assign o_PROT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dram_mux_model.sv
// Self-checking bench for dram_mux_model: vector table, hand-written corner
// sequences and randomized page-mode traffic against a location-level model.
module tb_dram_mux_model;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] addr;
   logic [3:0] din;
   logic [3:0] dout;
   logic       dvalid;
   logic       ras_n, cas_n, wr_n, rd_n;
   logic [7:0] ref_row;
   logic       prot;

   int n_checks = 0;
   int n_errors = 0;
   int exp_ref  = 0;
   bit [3:0] model [int];

`ifdef DRAM_MUX_PROT_CHECK_EN
   localparam int EXP_PROT = 1;
`else
   localparam int EXP_PROT = 0;
`endif

   always #5 clk = ~clk;

   dram_mux_model dut (
      .i_MCLK        (clk),
      .i_RST_n       (rst_n),
      .i_ADDR        (addr),
      .i_DIN         (din),
      .o_DOUT        (dout),
      .o_DOUT_VALID  (dvalid),
      .i_RAS_n       (ras_n),
      .i_CAS_n       (cas_n),
      .i_WR_n        (wr_n),
      .i_RD_n        (rd_n),
      .o_REFRESH_ROW (ref_row),
      .o_PROT_ERR    (prot)
   );

   typedef struct {
      logic [7:0] row;
      logic [5:0] col;
      bit         wr;
      logic [3:0] din;
      logic [3:0] exp_dout;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      ras_n = 1'b1;
      cas_n = 1'b1;
      wr_n  = 1'b1;
      rd_n  = 1'b1;
   endtask

   task automatic ras_open(input logic [7:0] row);
      addr  = row;
      ras_n = 1'b0;
      cyc();
   endtask

   task automatic ras_close();
      idle_bus();
      addr = 8'($urandom);
      cyc();
   endtask

   // One CAS pulse held low for two edges: latch, then one access
   task automatic cas_op(input logic [5:0] col, input bit wr, input logic [3:0] d,
                         output logic [3:0] q, output logic v);
      addr  = {1'b0, col, 1'b0};
      din   = d;
      wr_n  = ~wr;
      rd_n  = wr;
      cas_n = 1'b0;
      cyc();
      chk("valid_before_latency", dvalid, 0);
      addr = 8'($urandom);
      cyc();
      q = dout;
      v = dvalid;
      wr_n  = 1'b1;
      rd_n  = 1'b1;
      cas_n = 1'b1;
      cyc();
   endtask

   task automatic mop(input logic [7:0] row, input logic [5:0] col, input bit wr,
                      input logic [3:0] d, input string name);
      logic [3:0] q;
      logic       v;
      int         key;
      key = int'({col, row});
      cas_op(col, wr, d, q, v);
      if (wr) begin
         model[key] = d;
         chk({name, "_wr_valid"}, v, 0);
      end else begin
         chk({name, "_rd_valid"}, v, 1);
         chk({name, "_rd_data"}, q, model[key]);
      end
   endtask

   task automatic cbr(input bit cas_first);
      if (cas_first) begin
         cas_n = 1'b0;
         cyc();
      end
      cas_n = 1'b0;
      ras_n = 1'b0;
      cyc();
      exp_ref = (exp_ref + 1) % 256;
      chk("refresh_row_after_cbr", ref_row, exp_ref);
      idle_bus();
      cyc();
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_dout"}, dout, 0);
      chk({name, "_valid"}, dvalid, 0);
      chk({name, "_refresh"}, ref_row, 0);
      chk({name, "_prot"}, prot, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ras_n = 1'($urandom);
         cas_n = 1'($urandom);
         wr_n  = 1'($urandom);
         rd_n  = 1'($urandom);
         addr  = 8'($urandom);
         cyc();
         chk_reset_outputs("in_reset");
      end
      idle_bus();
      cyc();
      rst_n = 1'b1;
      exp_ref = 0;
      cyc();
      cyc();
      chk_reset_outputs("after_release");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] q;
      logic       v;
      logic [13:0] kk;

      tbl[0] = '{8'h5A, 6'h1E, 1'b1, 4'hB, 4'h0};
      tbl[1] = '{8'h5A, 6'h1E, 1'b0, 4'h0, 4'hB};
      tbl[2] = '{8'hFF, 6'h3F, 1'b1, 4'h7, 4'h0};
      tbl[3] = '{8'h00, 6'h00, 1'b1, 4'hE, 4'h0};
      tbl[4] = '{8'hFF, 6'h3F, 1'b0, 4'h0, 4'h7};
      tbl[5] = '{8'h00, 6'h00, 1'b0, 4'h0, 4'hE};
      tbl[6] = '{8'h5A, 6'h1F, 1'b1, 4'h3, 4'h0};
      tbl[7] = '{8'h5A, 6'h1E, 1'b0, 4'h0, 4'hB};
      tbl[8] = '{8'h5A, 6'h1F, 1'b0, 4'h0, 4'h3};

      rst_n = 1'b0;
      addr  = '0;
      din   = '0;
      idle_bus();
      do_reset();

      // Protocol flag: read strobe with RAS high, then a legal access
      rd_n = 1'b0;
      cyc();
      rd_n = 1'b1;
      cyc();
      chk("prot_set_after_idle_read", prot, EXP_PROT);
      ras_open(8'h77);
      mop(8'h77, 6'h2A, 1'b1, 4'h5, "prot_access");
      ras_close();
      chk("prot_sticky", prot, EXP_PROT);
      do_reset();

      // Three CBR cycles from reset
      for (int i = 0; i < 3; i++) cbr(i == 0);
      chk("refresh_row_three", ref_row, 3);

      // Single-access vector table
      for (int i = 0; i < 9; i++) begin
         ras_open(tbl[i].row);
         cas_op(tbl[i].col, tbl[i].wr, tbl[i].din, q, v);
         ras_close();
         if (tbl[i].wr) begin
            model[int'({tbl[i].col, tbl[i].row})] = tbl[i].din;
            chk($sformatf("tbl%0d_wr_valid", i), v, 0);
         end else begin
            chk($sformatf("tbl%0d_rd_valid", i), v, 1);
            chk($sformatf("tbl%0d_rd_data", i), q, tbl[i].exp_dout);
         end
      end

      // Page mode: four writes then four reads under one RAS each
      ras_open(8'h10);
      for (int i = 0; i < 4; i++) mop(8'h10, 6'(i), 1'b1, 4'(i + 1), "page_wr");
      ras_close();
      ras_open(8'h10);
      for (int i = 0; i < 4; i++) begin
         cas_op(6'(i), 1'b0, 4'h0, q, v);
         chk($sformatf("page_rd%0d_valid", i), v, 1);
         chk($sformatf("page_rd%0d_data", i), q, i + 1);
      end
      ras_close();

      // Late write then read inside one CAS-low window
      ras_open(8'h33);
      addr  = {1'b0, 6'h07, 1'b0};
      cas_n = 1'b0;
      cyc();
      wr_n = 1'b0;
      din  = 4'h6;
      cyc();
      wr_n = 1'b1;
      rd_n = 1'b0;
      cyc();
      chk("late_write_rd_valid", dvalid, 1);
      chk("late_write_rd_data", dout, 6);
      model[int'({6'h07, 8'h33})] = 4'h6;
      ras_close();

      // Write and read strobes together: write wins
      ras_open(8'h34);
      addr  = {1'b0, 6'h08, 1'b0};
      din   = 4'h9;
      wr_n  = 1'b0;
      rd_n  = 1'b0;
      cas_n = 1'b0;
      cyc();
      cyc();
      chk("wr_rd_both_no_valid", dvalid, 0);
      model[int'({6'h08, 8'h34})] = 4'h9;
      ras_close();
      ras_open(8'h34);
      mop(8'h34, 6'h08, 1'b0, 4'h0, "wr_rd_both_readback");
      ras_close();

      // Remaining CBRs to wrap the refresh counter
      for (int i = 0; i < 253; i++) cbr(1'b0);
      chk("refresh_row_wrap", ref_row, 0);

      // Hidden refresh after a read of column 0x05
      ras_open(8'h22);
      mop(8'h22, 6'h05, 1'b1, 4'hC, "hidden_prep");
      ras_close();
      ras_open(8'h22);
      addr  = {1'b0, 6'h05, 1'b0};
      rd_n  = 1'b0;
      cas_n = 1'b0;
      cyc();
      cyc();
      chk("hidden_rd_data", dout, 4'hC);
      rd_n  = 1'b1;
      wr_n  = 1'b0;
      din   = 4'h3;
      ras_n = 1'b1;
      cyc();
      ras_n = 1'b0;
      cyc();
      exp_ref = (exp_ref + 1) % 256;
      chk("hidden_refresh_row", ref_row, exp_ref);
      cyc();
      chk("hidden_dout_hold", dout, 4'hC);
      chk("hidden_no_valid", dvalid, 0);
      idle_bus();
      cyc();
      ras_open(8'h22);
      mop(8'h22, 6'h05, 1'b0, 4'h0, "hidden_no_write");
      ras_close();

      // Randomized page-mode traffic against the location model
      for (int t = 0; t < 150; t++) begin
         logic [7:0] row;
         int         nops;
         if ($urandom_range(0, 7) == 0) cbr(1'($urandom));
         row  = 8'h40 + 8'($urandom_range(0, 3));
         nops = $urandom_range(1, 4);
         ras_open(row);
         for (int k = 0; k < nops; k++) begin
            logic [5:0] col;
            bit         wr;
            col = 6'($urandom_range(0, 7));
            wr  = 1'($urandom);
            if (!model.exists(int'({col, row}))) wr = 1'b1;
            mop(row, col, wr, 4'($urandom), "rand");
         end
         ras_close();
      end

      // Reset in the middle of a write: outputs clear, write is dropped
      ras_open(8'h5A);
      mop(8'h5A, 6'h1E, 1'b0, 4'h0, "pre_reset_read");
      addr  = {1'b0, 6'h1E, 1'b0};
      din   = 4'h4;
      wr_n  = 1'b0;
      cas_n = 1'b0;
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_access_reset");
      idle_bus();
      cyc();
      cyc();
      rst_n = 1'b1;
      exp_ref = 0;
      cyc();
      chk_reset_outputs("mid_access_release");

      // Every modelled location must still hold its data
      foreach (model[key]) begin
         kk = key[13:0];
         ras_open(kk[7:0]);
         mop(kk[7:0], kk[13:8], 1'b0, 4'h0, "final_reread");
         ras_close();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
